// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
//   DATA_BITS  : payload bits per frame
//   BAUD_W     : width of the cycles-per-bit setting and bit counters
//   IDLE_LEVEL : serial line level when no frame is in flight
//   uart_state_e : frame FSM state encoding
//   cnt_load() : down-counter load value for a given period
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned BAUD_W     = 20;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Counters expire on zero, so a period of N cycles loads N-1 (saturating at 0).
  function automatic logic [BAUD_W-1:0] cnt_load(input logic [BAUD_W-1:0] period);
    return (period == '0) ? '0 : period - BAUD_W'(1);
  endfunction

endpackage

// File: rtl/dff_en.sv
// Standard register primitive: async active-high reset to RST_VAL, load on en.
//   clk, rst : clock, asynchronous reset
//   en       : load enable
//   d / q    : data in / registered data out
module dff_en #(
  parameter int unsigned W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/rx_sync.sv
// Serial input synchronizer plus registered falling-edge detector.
//   rx_in : asynchronous serial line
//   rx_s  : line after SYNC_STAGES flops
//   fall  : one-cycle pulse, registered, after rx_s goes 1 -> 0
module rx_sync import uart_pkg::*; #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic rx_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Flops reset to the idle level so reset release never fakes a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      prev_q <= IDLE_LEVEL;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      fall   <= prev_q & ~sync_q[SYNC_STAGES-1];
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver sampling each bit at its centre.
//   clk, rst  : clock, asynchronous active-high reset
//   rx_in     : serial line, idle high
//   baud      : clock cycles per bit, latched at each start edge
//   dout      : last good byte, held between good frames
//   valid     : one-cycle pulse when dout is updated
//   frame_err : one-cycle pulse when the stop bit sampled low
//   busy      : high while a frame is in progress
module uart_rx import uart_pkg::*; #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic [BAUD_W-1:0]    baud,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  logic rx_s;
  logic fall;

  logic [1:0]           state_q;
  uart_state_e          state, state_n;
  logic [BAUD_W-1:0]    cnt, cnt_n;
  logic [BAUD_W-1:0]    baud_q, baud_q_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic                 valid_n, frame_err_n, busy_n;
  logic                 expire;

  rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst   (rst),
    .rx_in (rx_in),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  assign state  = uart_state_e'(state_q);
  assign expire = (cnt == '0);

  // Next-state, counter, shifter and strobe logic.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    baud_q_n    = baud_q;
    shift_n     = shift;
    bit_idx_n   = bit_idx;
    valid_n     = 1'b0;
    frame_err_n = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (fall) begin
          state_n  = ST_START;
          baud_q_n = baud;
          // Half a period puts the start sample, and every later one, mid-bit.
          cnt_n    = cnt_load(baud >> 1);
        end
      end
      ST_START: begin
        if (!expire) begin
          cnt_n = cnt - BAUD_W'(1);
        end else if (rx_s) begin
          state_n = ST_IDLE;
        end else begin
          state_n   = ST_DATA;
          cnt_n     = cnt_load(baud_q);
          bit_idx_n = '0;
        end
      end
      ST_DATA: begin
        if (!expire) begin
          cnt_n = cnt - BAUD_W'(1);
        end else begin
          shift_n = {rx_s, shift[DATA_BITS-1:1]};
          cnt_n   = cnt_load(baud_q);
          if (bit_idx == IDX_W'(DATA_BITS - 1)) state_n = ST_STOP;
          else                                  bit_idx_n = bit_idx + IDX_W'(1);
        end
      end
      ST_STOP: begin
        if (!expire) begin
          cnt_n = cnt - BAUD_W'(1);
        end else begin
          state_n     = ST_IDLE;
          valid_n     = rx_s;
          frame_err_n = ~rx_s;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  dff_en #(.W(2), .RST_VAL(ST_IDLE)) u_state (
    .clk(clk), .rst(rst), .en(1'b1), .d(state_n), .q(state_q));
  dff_en #(.W(BAUD_W)) u_cnt (
    .clk(clk), .rst(rst), .en(1'b1), .d(cnt_n), .q(cnt));
  dff_en #(.W(BAUD_W)) u_baud (
    .clk(clk), .rst(rst), .en(1'b1), .d(baud_q_n), .q(baud_q));
  dff_en #(.W(DATA_BITS)) u_shift (
    .clk(clk), .rst(rst), .en(1'b1), .d(shift_n), .q(shift));
  dff_en #(.W(IDX_W)) u_idx (
    .clk(clk), .rst(rst), .en(1'b1), .d(bit_idx_n), .q(bit_idx));
  // dout only moves on a good stop bit.
  dff_en #(.W(DATA_BITS)) u_dout (
    .clk(clk), .rst(rst), .en(valid_n), .d(shift), .q(dout));
  dff_en #(.W(1)) u_valid (
    .clk(clk), .rst(rst), .en(1'b1), .d(valid_n), .q(valid));
  dff_en #(.W(1)) u_ferr (
    .clk(clk), .rst(rst), .en(1'b1), .d(frame_err_n), .q(frame_err));
  dff_en #(.W(1)) u_busy (
    .clk(clk), .rst(rst), .en(1'b1), .d(busy_n), .q(busy));

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames.
// A reference model predicts each strobe from the recorded line and baud history.
module tb_uart_rx;

  localparam int S    = 2;
  localparam int MAXC = 40000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_in;
  logic [19:0] baud;
  logic [7:0]  dout;
  logic        valid, frame_err, busy;

  uart_rx #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .baud(baud),
    .dout(dout), .valid(valid), .frame_err(frame_err), .busy(busy));

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   line_hist [MAXC];
  int   baud_hist [MAXC];
  int   pend [$];          // T0 cycle of each frame that must produce a strobe
  logic [7:0] last_good = 8'h00;
  int   valid_cyc = -1000;
  int   valid_prev = -1000;
  int   last_ev = -1000;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Reference model: rx_s at cycle t equals the line at t-S; a frame with
  // start edge at T0 samples bit k at T0+h+(k+1)*b and stop at T0+h+9*b,
  // with b the baud present at T0 and h=b>>1; the strobe follows one cycle later.
  initial forever begin
    int t0, bq, h, ss;
    logic [7:0] exp_d;
    bit exp_ok;
    @(negedge clk);
    if (cyc < MAXC) begin
      line_hist[cyc] = rx_in;
      baud_hist[cyc] = int'(baud);
    end
    if (rst) begin
      last_good = 8'h00;
      while (pend.size() != 0) void'(pend.pop_front());
    end else if (valid || frame_err) begin
      check_eq("strobe_not_consecutive", 32'(last_ev == cyc - 1), 32'd0);
      check_eq("strobe_mutex", 32'(valid & frame_err), 32'd0);
      check_eq("busy_low_at_strobe", 32'(busy), 32'd0);
      last_ev = cyc;
      if (pend.size() == 0) begin
        check_eq("spurious_strobe", 32'd1, 32'd0);
      end else begin
        t0 = pend.pop_front();
        bq = baud_hist[t0];
        h  = bq >> 1;
        ss = t0 + h + 9 * bq;
        for (int k = 0; k < 8; k++) exp_d[k] = line_hist[t0 + h + (k + 1) * bq - S];
        exp_ok = line_hist[ss - S];
        check_eq("strobe_cycle", 32'(cyc), 32'(ss + 1));
        check_eq("valid", 32'(valid), 32'(exp_ok));
        check_eq("frame_err", 32'(frame_err), 32'(!exp_ok));
        if (exp_ok) last_good = exp_d;
        check_eq("dout", 32'(dout), 32'(last_good));
        if (valid) begin
          valid_prev = valid_cyc;
          valid_cyc  = cyc;
        end
      end
    end else if (pend.size() != 0 && cyc > pend[0]) begin
      t0 = pend[0];
      bq = baud_hist[t0];
      if (cyc > t0 + (bq >> 1) + 9 * bq + 1) begin
        check_eq("missing_strobe", 32'd0, 32'd1);
        void'(pend.pop_front());
      end
    end
  end

  // All drive tasks start and end #1 after a rising edge.
  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic send_frame(input logic [7:0] data, input bit stop, input int b,
                            input bit exp_ev, input int sw, input int nb,
                            input int abort, output int d0);
    logic [9:0] fr;
    fr = {stop, data, 1'b0};
    d0 = cyc;
    baud = 20'(b);
    if (exp_ev) pend.push_back(d0 + S + 1);
    for (int i = 0; i < 10 * b && i != abort; i++) begin
      if (i == sw) baud = 20'(nb);
      rx_in = fr[i / b];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && pend.size() != 0; i++) @(negedge clk);
    align();
  endtask

  initial begin
    int d, b, gap, len;
    bit stp;
    rst = 1'b1;
    rx_in = 1'b1;
    baud = 20'd16;
    repeat (3) @(negedge clk);
    check_eq("rst_dout", 32'(dout), 32'h00);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_frame_err", 32'(frame_err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    align();
    rst = 1'b0;
    idle(8);

    // Good frame and its absolute latency.
    send_frame(8'hA5, 1'b1, 16, 1'b1, -1, 0, -1, d);
    idle(4);
    check_eq("a5_latency", 32'(valid_cyc - (d + S + 1)), 32'd153);
    check_eq("a5_dout", 32'(dout), 32'hA5);

    // Bad stop bit, line held low, then recovery.
    send_frame(8'h3C, 1'b0, 16, 1'b1, -1, 0, -1, d);
    repeat (50) align();
    check_eq("ferr_dout_kept", 32'(dout), 32'hA5);
    idle(20);
    send_frame(8'h11, 1'b1, 16, 1'b1, -1, 0, -1, d);
    idle(4);
    check_eq("after_ferr_dout", 32'(dout), 32'h11);

    // Four-cycle glitch is a false start.
    d = cyc;
    baud = 20'd16;
    rx_in = 1'b0;
    repeat (4) align();
    rx_in = 1'b1;
    wait_cyc(d + S + 2);
    check_eq("fs_busy_t0p1", 32'(busy), 32'd1);
    wait_cyc(d + S + 9);
    check_eq("fs_busy_t0p8", 32'(busy), 32'd1);
    wait_cyc(d + S + 10);
    check_eq("fs_busy_t0p9", 32'(busy), 32'd0);
    align();
    idle(20);
    send_frame(8'h3C, 1'b1, 16, 1'b1, -1, 0, -1, d);
    idle(4);
    check_eq("fs_next_dout", 32'(dout), 32'h3C);

    // Back-to-back frames with no idle gap.
    idle(10);
    send_frame(8'h00, 1'b1, 16, 1'b1, -1, 0, -1, d);
    check_eq("b2b_first", 32'(dout), 32'h00);
    send_frame(8'hFF, 1'b1, 16, 1'b1, -1, 0, -1, d);
    idle(4);
    check_eq("b2b_gap", 32'(valid_cyc - valid_prev), 32'd160);
    check_eq("b2b_second", 32'(dout), 32'hFF);

    // Reset during data bit 3.
    idle(10);
    send_frame(8'hE7, 1'b1, 16, 1'b0, -1, 0, 4 * 16 + 8, d);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_dout", 32'(dout), 32'h00);
    check_eq("mid_rst_valid", 32'(valid | frame_err), 32'd0);
    rx_in = 1'b1;
    repeat (3) align();
    rst = 1'b0;
    idle(10);
    send_frame(8'h55, 1'b1, 16, 1'b1, -1, 0, -1, d);
    idle(4);
    check_eq("post_rst_dout", 32'(dout), 32'h55);

    // Baud change mid-frame only takes effect at the next start.
    idle(10);
    send_frame(8'hC3, 1'b1, 16, 1'b1, S + 1 + 40, 32, -1, d);
    idle(4);
    check_eq("baud_chg_cur", 32'(dout), 32'hC3);
    send_frame(8'h96, 1'b1, 32, 1'b1, -1, 0, -1, d);
    idle(4);
    check_eq("baud_chg_next", 32'(dout), 32'h96);

    // Randomized frames, bauds, stop bits, gaps and glitches.
    for (int f = 0; f < 24; f++) begin
      b = $urandom_range(4, 40);
      if ($urandom_range(0, 3) == 0) begin
        baud = 20'(b);
        len = $urandom_range(1, b >> 1);
        rx_in = 1'b0;
        repeat (len) align();
        idle(b + 8);
      end
      stp = ($urandom_range(0, 5) != 0);
      send_frame(8'($urandom), stp, b, 1'b1, -1, 0, -1, d);
      gap = $urandom_range(stp ? 0 : 1, 12);
      idle(gap);
    end

    idle(2);
    drain();
    check_eq("pending_empty", 32'(pend.size()), 32'd0);
    repeat (10) align();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
